// File: rtl/tx_stream_mux_pkg.sv
// Shared constants, FSM encoding and a clog2 helper for tx_stream_mux and other ROC arbiters.
package tx_stream_mux_pkg;

  localparam logic [15:0] IDLE_DATA_DEF  = 16'h3CBC;  // K28.5 in the low byte
  localparam logic [1:0]  IDLE_KCHAR_DEF = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SRC  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tx_stream_mux_prio_enc.sv
// Lowest-index-wins combinational priority encoder (tx_prio_enc).
module tx_prio_enc
  import tx_stream_mux_pkg::*;
#(
  parameter int N = 3,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !any) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_stream_mux.sv
// N-channel TX lane multiplexer with idle-boundary switching and GAP_LEN idle insertion.
// Optional forced cut after TIMEOUT cycles: define TX_STREAM_MUX_TIMEOUT_EN.
module tx_stream_mux
  import tx_stream_mux_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int DATA_W  = 16,
  localparam int K_W    = DATA_W / 8,
  localparam int CH_W   = clog2(N_CH),
  parameter logic [DATA_W-1:0] IDLE_DATA  = IDLE_DATA_DEF,
  parameter logic [K_W-1:0]    IDLE_KCHAR = IDLE_KCHAR_DEF,
  parameter int GAP_LEN = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                   TX_CLK,
  input  logic                   RESET,
  input  logic [N_CH-1:0]        CH_EN,
  input  logic [N_CH*DATA_W-1:0] CH_DATA,
  input  logic [N_CH*K_W-1:0]    CH_KCHAR,
  output logic [DATA_W-1:0]      TX_DATA,
  output logic [K_W-1:0]         TX_KCHAR,
  output logic                   ACTIVE_VALID,
  output logic [CH_W-1:0]        ACTIVE_CH,
  output logic [15:0]            SWITCH_CNT
);

  if (N_CH < 2 || N_CH > 8) begin : g_bad_n_ch
    $error("tx_stream_mux: N_CH must be 2..8");
  end
  if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("tx_stream_mux: DATA_W must be a non-zero multiple of 8");
  end
  if (GAP_LEN < 1 || GAP_LEN > 15) begin : g_bad_gap_len
    $error("tx_stream_mux: GAP_LEN must be 1..15");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("tx_stream_mux: TIMEOUT must be >= 1");
  end

  state_t              state_q, state_d;
  logic [CH_W-1:0]     owner_q, owner_d;
  logic [3:0]          gap_q, gap_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [K_W-1:0]      k_q, k_d;
  logic                valid_q, valid_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                cnt_inc;

  logic [CH_W-1:0]     win;
  logic                win_any;
  logic [DATA_W-1:0]   own_data;
  logic [K_W-1:0]      own_k;
  logic                own_en;
  logic                boundary;
  logic                timeout_hit;

  tx_prio_enc #(.N(N_CH), .W(CH_W)) u_prio_enc (
    .req (CH_EN),
    .idx (win),
    .any (win_any)
  );

  assign own_data = CH_DATA[int'(owner_q)*DATA_W +: DATA_W];
  assign own_k    = CH_KCHAR[int'(owner_q)*K_W +: K_W];
  assign own_en   = CH_EN[owner_q];
  assign boundary = (own_data == IDLE_DATA) && (own_k == IDLE_KCHAR);

`ifdef TX_STREAM_MUX_TIMEOUT_EN
  localparam int TO_W = clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            pending;

  // Counter is held at zero outside S_SRC, so every S_SRC entry starts from zero.
  assign pending     = (state_q == S_SRC) && own_en && (win != owner_q) && !boundary;
  assign timeout_hit = pending && (to_q == TO_W'(TIMEOUT - 1));
  assign to_d        = (pending && !timeout_hit) ? to_q + 1'b1 : '0;

  always_ff @(posedge TX_CLK or posedge RESET) begin
    if (RESET) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gap_d   = gap_q;
    data_d  = IDLE_DATA;
    k_d     = IDLE_KCHAR;
    valid_d = valid_q;
    cnt_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        owner_d = '0;
        if (win_any) begin
          state_d = S_SRC;
          owner_d = win;
          valid_d = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      S_SRC: begin
        data_d = own_data;
        k_d    = own_k;
        // An owner drop beats a pending preemption; the cut word is replaced by idle.
        if (!own_en || timeout_hit) begin
          data_d  = IDLE_DATA;
          k_d     = IDLE_KCHAR;
          state_d = S_GAP;
          owner_d = '0;
          valid_d = 1'b0;
          gap_d   = '0;
        end else if ((win != owner_q) && boundary) begin
          state_d = S_GAP;
          owner_d = '0;
          valid_d = 1'b0;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_q == 4'(GAP_LEN - 1)) begin
          gap_d = '0;
          if (win_any) begin
            state_d = S_SRC;
            owner_d = win;
            valid_d = 1'b1;
            cnt_inc = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = '0;
        valid_d = 1'b0;
        gap_d   = '0;
      end
    endcase
    cnt_d = (cnt_inc && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge TX_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      gap_q   <= '0;
      data_q  <= IDLE_DATA;
      k_q     <= IDLE_KCHAR;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign TX_DATA      = data_q;
  assign TX_KCHAR     = k_q;
  assign ACTIVE_VALID = valid_q;
  assign ACTIVE_CH    = owner_q;
  assign SWITCH_CNT   = cnt_q;

endmodule
